// File: rtl/traffic_light_fsm_if.sv
// Timer handshake between the intersection sequencer (master) and the Timer (slave).
// The master pulses start_timer for one cycle with the interval in value; the Timer
// answers with a one-cycle expired pulse once that interval has elapsed.
interface traffic_light_fsm_if;
  logic       start_timer;
  logic [3:0] value;
  logic       expired;

  modport master (
    output start_timer,
    output value,
    input  expired
  );

  modport slave (
    input  start_timer,
    input  value,
    output expired
  );
endinterface

// File: rtl/traffic_light_fsm.sv
// Intersection sequencing controller. Chooses each light phase and its duration,
// arms the Timer via the handshake interface and advances on the expired pulse.
// Optional night flashing mode is compiled in when TLC_NIGHT_MODE_EN is defined.
module traffic_light_fsm #(
  parameter int unsigned T_BASE = 6,  // main/side base green, seconds
  parameter int unsigned T_EXT  = 3,  // side green extension, seconds
  parameter int unsigned T_YEL  = 2,  // yellow, seconds
  parameter int unsigned T_WALK = 3   // all-red walk, seconds
) (
  input  logic                       clock,
  input  logic                       reset_n,
  traffic_light_fsm_if.master        tmr,
  input  logic                       sensor,
  input  logic                       walk_request,
`ifdef TLC_NIGHT_MODE_EN
  input  logic                       night_mode,
`endif
  output logic [2:0]                 main_lights,
  output logic [2:0]                 side_lights,
  output logic                       walk_light
);

  // A zero interval would make the Timer wrap and count 16 ticks.
  if (T_BASE < 1 || T_BASE > 15 || T_EXT < 1 || T_EXT > 15 ||
      T_YEL < 1 || T_YEL > 15 || T_WALK < 1 || T_WALK > 15) begin : g_param_err
    $error("traffic_light_fsm: every duration parameter must be in 1..15");
  end

  localparam logic [3:0] DurBase = 4'(T_BASE);
  localparam logic [3:0] DurExt  = 4'(T_EXT);
  localparam logic [3:0] DurYel  = 4'(T_YEL);
  localparam logic [3:0] DurWalk = 4'(T_WALK);

  // Lamp codes are {red, yellow, green}.
  localparam logic [2:0] LampRed = 3'b100;
  localparam logic [2:0] LampYel = 3'b010;
  localparam logic [2:0] LampGrn = 3'b001;
  localparam logic [2:0] LampOff = 3'b000;

  typedef enum logic [2:0] {
    StMainGreen,
    StMainYellow,
    StSideGreen,
    StSideGreenExt,
    StSideYellow,
    StWalk
`ifdef TLC_NIGHT_MODE_EN
    , StNightFlash
`endif
  } state_e;

  state_e     state;
  state_e     next_state;
  logic       walk_pending;
  logic       kick;
  logic       advance;
  logic       enter_walk;
  logic [3:0] next_value;
  logic [2:0] next_main;
  logic [2:0] next_side;
  logic       next_walk;
`ifdef TLC_NIGHT_MODE_EN
  logic       flash;
  logic       next_flash;
`endif

  // Transition on an accepted expiry; expiries during kick or a start pulse are ignored.
  always_comb begin
    advance    = !kick && !tmr.start_timer && tmr.expired;
    next_state = state;
`ifdef TLC_NIGHT_MODE_EN
    next_flash = flash;
`endif
    if (advance) begin
      unique case (state)
        StMainGreen: begin
`ifdef TLC_NIGHT_MODE_EN
          if (night_mode) begin
            next_state = StNightFlash;
            next_flash = 1'b0;
          end else
`endif
          if (sensor) begin
            next_state = StMainYellow;
          end else begin
            next_state = StMainGreen;
          end
        end
        StMainYellow:   next_state = StSideGreen;
        StSideGreen:    next_state = sensor ? StSideGreenExt : StSideYellow;
        StSideGreenExt: next_state = StSideYellow;
        StSideYellow:   next_state = walk_pending ? StWalk : StMainGreen;
        StWalk:         next_state = StMainGreen;
`ifdef TLC_NIGHT_MODE_EN
        StNightFlash: begin
          if (night_mode) begin
            next_state = StNightFlash;
            next_flash = !flash;
          end else begin
            next_state = StMainGreen;
          end
        end
`endif
        default:        next_state = StMainGreen;
      endcase
    end
    enter_walk = advance && (next_state == StWalk);
  end

  // Duration and Moore lamp decode of the state being entered.
  always_comb begin
    next_value = DurBase;
    next_main  = LampGrn;
    next_side  = LampRed;
    next_walk  = 1'b0;
    unique case (next_state)
      StMainGreen: begin
        next_value = DurBase;
        next_main  = LampGrn;
        next_side  = LampRed;
      end
      StMainYellow: begin
        next_value = DurYel;
        next_main  = LampYel;
        next_side  = LampRed;
      end
      StSideGreen: begin
        next_value = DurBase;
        next_main  = LampRed;
        next_side  = LampGrn;
      end
      StSideGreenExt: begin
        next_value = DurExt;
        next_main  = LampRed;
        next_side  = LampGrn;
      end
      StSideYellow: begin
        next_value = DurYel;
        next_main  = LampRed;
        next_side  = LampYel;
      end
      StWalk: begin
        next_value = DurWalk;
        next_main  = LampRed;
        next_side  = LampRed;
        next_walk  = 1'b1;
      end
`ifdef TLC_NIGHT_MODE_EN
      StNightFlash: begin
        next_value = 4'd1;
        next_main  = next_flash ? LampOff : LampYel;
        next_side  = next_flash ? LampOff : LampRed;
      end
`endif
      default: begin
        next_value = DurBase;
      end
    endcase
  end

  // Sequencer state, walk latch, Timer handshake and registered lamps.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= StMainGreen;
      walk_pending    <= 1'b0;
      kick            <= 1'b1;
      tmr.start_timer <= 1'b0;
      tmr.value       <= 4'd0;
      main_lights     <= LampGrn;
      side_lights     <= LampRed;
      walk_light      <= 1'b0;
`ifdef TLC_NIGHT_MODE_EN
      flash           <= 1'b0;
`endif
    end else begin
      // Clear wins only on the entering edge; requests made during WALK are kept.
      if (enter_walk) begin
        walk_pending <= 1'b0;
      end else if (walk_request) begin
        walk_pending <= 1'b1;
      end

      if (kick) begin
        kick            <= 1'b0;
        tmr.start_timer <= 1'b1;
        tmr.value       <= DurBase;
      end else if (advance) begin
        state           <= next_state;
        tmr.start_timer <= 1'b1;
        tmr.value       <= next_value;
        main_lights     <= next_main;
        side_lights     <= next_side;
        walk_light      <= next_walk;
`ifdef TLC_NIGHT_MODE_EN
        flash           <= next_flash;
`endif
      end else begin
        tmr.start_timer <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Self-checking bench for traffic_light_fsm: a directed vector table, hand-written
// corner sequences and a randomized run against a phase-table reference model.
// Night mode checks are compiled in with TLC_NIGHT_MODE_EN.
module tb_traffic_light_fsm;

  localparam int unsigned T_BASE = 6;
  localparam int unsigned T_EXT  = 3;
  localparam int unsigned T_YEL  = 2;
  localparam int unsigned T_WALK = 3;

  // Phase indices of the reference model.
  localparam int P_MG    = 0;
  localparam int P_MY    = 1;
  localparam int P_SG    = 2;
  localparam int P_SGE   = 3;
  localparam int P_SY    = 4;
  localparam int P_WALK  = 5;
  localparam int P_NIGHT = 6;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       sensor;
  logic       walk_request;
  logic       night_mode;
  logic [2:0] main_lights;
  logic [2:0] side_lights;
  logic       walk_light;

  traffic_light_fsm_if tif ();

  traffic_light_fsm #(
    .T_BASE (T_BASE),
    .T_EXT  (T_EXT),
    .T_YEL  (T_YEL),
    .T_WALK (T_WALK)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .tmr          (tif.master),
    .sensor       (sensor),
    .walk_request (walk_request),
`ifdef TLC_NIGHT_MODE_EN
    .night_mode   (night_mode),
`endif
    .main_lights  (main_lights),
    .side_lights  (side_lights),
    .walk_light   (walk_light)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: phase tables taken straight from the phase list.
  int         phase_dur   [7] = '{T_BASE, T_YEL, T_BASE, T_EXT, T_YEL, T_WALK, 1};
  logic [6:0] phase_lamps [7] = '{7'b001_100_0, 7'b010_100_0, 7'b100_001_0, 7'b100_001_0,
                                  7'b100_010_0, 7'b100_100_1, 7'b010_100_0};
  int m_phase;
  bit m_flash, m_pending, m_kick, m_start;
  int m_val;

  // Timer environment model.
  int tcnt;
  int tick;
  bit force_exp;

  typedef struct {
    bit         sensor;
    bit         walk;
    logic [3:0] value;
    logic [2:0] main;
    logic [2:0] side;
    bit         walk_l;
  } vec_t;
  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase   = P_MG;
    m_flash   = 1'b0;
    m_pending = 1'b0;
    m_kick    = 1'b1;
    m_start   = 1'b0;
    m_val     = 0;
    tcnt      = 0;
  endtask

  function automatic logic [6:0] model_lamps();
    if (m_phase == P_NIGHT && m_flash) return 7'b000_000_0;
    return phase_lamps[m_phase];
  endfunction

  // Advance the model by one accepted expiry using the phase rules.
  task automatic model_advance(output bit entered_walk);
    int nxt;
    nxt = m_phase;
    case (m_phase)
      P_MG: begin
        if (night_mode === 1'b1) begin
          nxt     = P_NIGHT;
          m_flash = 1'b0;
        end else begin
          nxt = sensor ? P_MY : P_MG;
        end
      end
      P_MY:    nxt = P_SG;
      P_SG:    nxt = sensor ? P_SGE : P_SY;
      P_SGE:   nxt = P_SY;
      P_SY:    nxt = m_pending ? P_WALK : P_MG;
      P_WALK:  nxt = P_MG;
      P_NIGHT: begin
        if (night_mode === 1'b1) m_flash = !m_flash;
        else nxt = P_MG;
      end
      default: nxt = P_MG;
    endcase
    entered_walk = (nxt == P_WALK) && (m_phase != P_WALK);
    m_phase = nxt;
    m_start = 1'b1;
    m_val   = phase_dur[nxt];
  endtask

  // One clock: drive expired, predict, clock, compare, update Timer model.
  task automatic step();
    bit ew;
    logic [6:0] lamps;
    ew = 1'b0;
    tif.expired = force_exp || (tcnt == 1);
    if (reset_n) begin
      if (m_kick) begin
        m_kick  = 1'b0;
        m_start = 1'b1;
        m_val   = phase_dur[P_MG];
      end else if (m_start) begin
        m_start = 1'b0;
      end else if (tif.expired) begin
        model_advance(ew);
      end
      if (ew) m_pending = 1'b0;
      else if (walk_request) m_pending = 1'b1;
    end
    @(posedge clock);
    #1;
    lamps = model_lamps();
    check("start_timer", tif.start_timer, m_start);
    if (!reset_n || m_start) check("value", tif.value, m_val);
    check("main_lights", main_lights, lamps[6:4]);
    check("side_lights", side_lights, lamps[3:1]);
    check("walk_light", walk_light, lamps[0]);
    // The Timer samples start_timer on the next edge, then counts value*tick cycles.
    if (tif.start_timer === 1'b1) tcnt = int'(tif.value) * tick + 1;
    else if (tcnt > 0) tcnt--;
  endtask

  task automatic wait_start(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (tif.start_timer === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check({name, " start_timer seen"}, seen, 1);
  endtask

  task automatic check_pulse(input string name, input logic [3:0] v, input logic [2:0] ml,
                             input logic [2:0] sl, input logic wl);
    wait_start(name);
    check({name, " value"}, tif.value, v);
    check({name, " main"}, main_lights, ml);
    check({name, " side"}, side_lights, sl);
    check({name, " walk"}, walk_light, wl);
  endtask

  initial begin
    int cnt;
    vecs[0] = '{0, 0, 4'd6, 3'b001, 3'b100, 0};  // kick after reset
    vecs[1] = '{0, 0, 4'd6, 3'b001, 3'b100, 0};  // MAIN_GREEN restart
    vecs[2] = '{1, 1, 4'd2, 3'b010, 3'b100, 0};  // MAIN_YELLOW, walk requested
    vecs[3] = '{1, 0, 4'd6, 3'b100, 3'b001, 0};  // SIDE_GREEN
    vecs[4] = '{1, 0, 4'd3, 3'b100, 3'b001, 0};  // SIDE_GREEN_EXT
    vecs[5] = '{1, 0, 4'd2, 3'b100, 3'b010, 0};  // SIDE_YELLOW
    vecs[6] = '{0, 0, 4'd3, 3'b100, 3'b100, 1};  // WALK
    vecs[7] = '{0, 0, 4'd6, 3'b001, 3'b100, 0};  // MAIN_GREEN, request consumed
    vecs[8] = '{0, 0, 4'd6, 3'b001, 3'b100, 0};  // MAIN_GREEN restart

    reset_n      = 1'b0;
    sensor       = 1'b0;
    walk_request = 1'b0;
    night_mode   = 1'b0;
    force_exp    = 1'b0;
    tick         = 4;
    tif.expired  = 1'b0;
    model_reset();
    step();
    step();
    #3 reset_n = 1'b1;

    // Directed vector table.
    for (int i = 0; i < 9; i++) begin
      sensor       = vecs[i].sensor;
      walk_request = vecs[i].walk;
      wait_start($sformatf("vec%0d", i));
      check($sformatf("vec%0d value", i), tif.value, vecs[i].value);
      check($sformatf("vec%0d main", i), main_lights, vecs[i].main);
      check($sformatf("vec%0d side", i), side_lights, vecs[i].side);
      check($sformatf("vec%0d walk", i), walk_light, vecs[i].walk_l);
    end
    walk_request = 1'b0;

    // Expired coinciding with start_timer must not advance or re-pulse.
    force_exp = 1'b1;
    step();
    force_exp = 1'b0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (tif.start_timer === 1'b1) cnt++;
    end
    check("ignored expired extra pulses", cnt, 0);
    check("ignored expired main", main_lights, 3'b001);

    // One-cycle walk pulse, then the side cycle with extension and WALK.
    walk_request = 1'b1;
    step();
    walk_request = 1'b0;
    sensor = 1'b1;
    check_pulse("pulse MY", 4'd2, 3'b010, 3'b100, 1'b0);
    check_pulse("pulse SG", 4'd6, 3'b100, 3'b001, 1'b0);
    check_pulse("pulse SGE", 4'd3, 3'b100, 3'b001, 1'b0);
    check_pulse("pulse SY", 4'd2, 3'b100, 3'b010, 1'b0);
    check_pulse("pulse WALK", 4'd3, 3'b100, 3'b100, 1'b1);
    sensor = 1'b0;
    check_pulse("pulse MG", 4'd6, 3'b001, 3'b100, 1'b0);

    // Asynchronous reset in the middle of SIDE_GREEN_EXT.
    sensor = 1'b1;
    check_pulse("pre MY", 4'd2, 3'b010, 3'b100, 1'b0);
    check_pulse("pre SG", 4'd6, 3'b100, 3'b001, 1'b0);
    check_pulse("pre SGE", 4'd3, 3'b100, 3'b001, 1'b0);
    step();
    step();
    step();
    #2 reset_n = 1'b0;
    #1;
    check("async rst start_timer", tif.start_timer, 0);
    check("async rst value", tif.value, 0);
    check("async rst main", main_lights, 3'b001);
    check("async rst side", side_lights, 3'b100);
    check("async rst walk", walk_light, 0);
    model_reset();
    sensor = 1'b0;
    step();
    step();
    #3 reset_n = 1'b1;
    force_exp = 1'b1;  // expiry during the kick cycle is ignored
    step();
    force_exp = 1'b0;
    check("kick start_timer", tif.start_timer, 1);
    check("kick value", tif.value, 6);
    step();
    check("kick single pulse", tif.start_timer, 0);

`ifdef TLC_NIGHT_MODE_EN
    night_mode = 1'b1;
    check_pulse("night ph0", 4'd1, 3'b010, 3'b100, 1'b0);
    check_pulse("night ph1", 4'd1, 3'b000, 3'b000, 1'b0);
    check_pulse("night ph0b", 4'd1, 3'b010, 3'b100, 1'b0);
    night_mode = 1'b0;
    check_pulse("night exit", 4'd6, 3'b001, 3'b100, 1'b0);
`endif

    // Randomized run against the reference model.
    tick = 1;
    for (int i = 0; i < 3000; i++) begin
      sensor       = 1'($urandom_range(0, 1));
      walk_request = ($urandom_range(0, 15) == 0);
      force_exp    = ($urandom_range(0, 31) == 0);
`ifdef TLC_NIGHT_MODE_EN
      if ($urandom_range(0, 63) == 0) night_mode = !night_mode;
`endif
      step();
    end
    force_exp = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_light_fsm.md
Name: traffic_light_fsm

Overview:
- Sequencing controller for the intersection and the initiator side of the Timer interface.
- Chooses each light phase and its duration, issues start_timer/value to the Timer, and advances on the Timer's expired pulse.
- Also consumes the side-street car sensor and the pedestrian walk button.
- Drives the main-street, side-street and walk lamps.

Parameters:
- T_BASE, 6, main/side base green duration in seconds (legal 1..15).
- T_EXT, 3, side-green extension in seconds (legal 1..15).
- T_YEL, 2, yellow duration in seconds (legal 1..15).
- T_WALK, 3, all-red walk phase in seconds (legal 1..15).

Ports:
- clock  input  1  system clock; all state changes on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- expired  input  1  one-cycle pulse from Timer; the programmed interval has elapsed.
- sensor  input  1  car waiting on side street (level, sampled).
- walk_request  input  1  pedestrian button (level or pulse).
- start_timer  output  1  one-cycle pulse; Timer loads value.
- value  output  4  seconds to program; valid when start_timer=1.
- main_lights  output  3  {red,yellow,green} for main street.
- side_lights  output  3  {red,yellow,green} for side street.
- walk_light  output  1  pedestrian walk lamp.

Behaviour:
- Reset (reset_n=0, async):
  - state=MAIN_GREEN, walk_pending=0, start_timer=0, value=0.
  - kick=1, main_lights=001, side_lights=100, walk_light=0.
- First rising edge after reset release (kick=1): start_timer=1, value=T_BASE for one cycle; kick cleared.
- All outputs are registered. Lamp outputs are a Moore decode of the next state, so they change on the same edge as the state.
- States, lamps (main/side/walk), and what happens on expired:
  - MAIN_GREEN (001/100/0), T_BASE: if sensor=1 go to MAIN_YELLOW; else stay in MAIN_GREEN and restart with T_BASE.
  - MAIN_YELLOW (010/100/0), T_YEL: go to SIDE_GREEN.
  - SIDE_GREEN (100/001/0), T_BASE: if sensor=1 go to SIDE_GREEN_EXT; else go to SIDE_YELLOW.
  - SIDE_GREEN_EXT (100/001/0), T_EXT: go to SIDE_YELLOW (no further extension).
  - SIDE_YELLOW (100/010/0), T_YEL: if walk_pending go to WALK; else go to MAIN_GREEN.
  - WALK (100/100/1), T_WALK: go to MAIN_GREEN.
- Timer handshake:
  - Every expired-triggered transition, including a MAIN_GREEN self-restart, yields start_timer=1 in the following cycle.
  - value carries the new state's duration in that same cycle.
  - expired is ignored while start_timer=1 or kick=1. Only an expired seen with start_timer=0 advances the FSM.
  - Exactly one start_timer pulse per expired pulse; never two consecutive start_timer cycles.
- walk_pending:
  - Set on any cycle walk_request=1.
  - Cleared on the edge entering WALK.
  - A request during WALK itself is kept and served on the next cycle.
  - Set has priority over clear only when the request occurs after WALK entry.
- Sampling: sensor is sampled only in the expired cycle; sensor changes at other times have no effect.
- Parameter check: an elaboration-time check flags any parameter of 0 or above 15. A value of 0 would make the Timer count 16 ticks.
- Reset mid-operation: immediate return to the reset values above, independent of clock; the kick sequence repeats after release.

Optional Feature:
- Macro: TLC_NIGHT_MODE_EN.
- When defined:
  - Adds input port night_mode (1 bit) and state NIGHT_FLASH.
  - At a MAIN_GREEN expiry with night_mode=1, go to NIGHT_FLASH with value=1.
  - In NIGHT_FLASH, each expired toggles a phase bit and re-arms the timer with value=1.
  - Phase 0: main_lights=010, side_lights=100. Phase 1: both 000. walk_light=0 throughout.
  - At an expiry with night_mode=0, go to MAIN_GREEN (value=T_BASE).
  - walk_pending is held and served on the normal path.
- When undefined: no port and no state; behaviour exactly as above.

Test Plan:
- Reset release, no sensor, Timer model with tick every 4 clocks → start_timer pulse value=6 on first edge; MAIN_GREEN restarts with value=6 on each expiry; lamps stay 001/100.
- sensor=1 held → MAIN_GREEN→MAIN_YELLOW(value=2)→SIDE_GREEN(6)→SIDE_GREEN_EXT(3)→SIDE_YELLOW(2)→MAIN_GREEN(6), with a lamp check at each step.
- One-cycle walk_request pulse during MAIN_GREEN, sensor=1 → after SIDE_YELLOW enter WALK(value=3), lamps 100/100/1, walk_pending cleared, then MAIN_GREEN.
- expired asserted in the same cycle as start_timer=1 → ignored; state unchanged; no extra start_timer pulse.
- reset_n dropped mid-SIDE_GREEN_EXT, between clock edges → outputs go to reset values asynchronously; after release, kick pulse with value=6.
- With TLC_NIGHT_MODE_EN, night_mode=1 at a MAIN_GREEN expiry → NIGHT_FLASH with main_lights alternating 010/000 every expiry at value=1; night_mode=0 → MAIN_GREEN with value=6.
